// File: rtl/ex_dm_pkg.sv
// EX->DM pipeline stage shared definitions:
// state encoding and default widths.
package ex_dm_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int RD_W_DEF   = 5;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   // Encoding equals entry count, so occupancy is the state itself.
   function automatic logic [1:0] occ_of(state_e s);
      return logic'(s == FULL) ? 2'd2 : (s == ONE) ? 2'd1 : 2'd0;
   endfunction

endpackage

// File: rtl/ex_dm_stage_if.sv
// Handshake and payload bundle between EX, the EX/DM
// stage and data memory.
interface ex_dm_stage_if
   import ex_dm_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_W   = RD_W_DEF
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] write_data_in;
   logic              mem_read_in;
   logic              mem_write_in;
   logic              reg_write_in;
   logic [RD_W-1:0]   rd_in;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] mem_address;
   logic [DATA_W-1:0] write_data_out;
   logic              mem_read_out;
   logic              mem_write_out;
   logic              reg_write_out;
   logic [RD_W-1:0]   rd_out;
   logic [1:0]        occupancy;

   modport master (
      output in_valid, alu_result, write_data_in,
      output mem_read_in, mem_write_in, reg_write_in, rd_in,
      input  in_ready,
      output out_ready,
      input  out_valid, mem_address, write_data_out,
      input  mem_read_out, mem_write_out, reg_write_out,
      input  rd_out, occupancy
   );

   modport slave (
      input  in_valid, alu_result, write_data_in,
      input  mem_read_in, mem_write_in, reg_write_in, rd_in,
      output in_ready,
      input  out_ready,
      output out_valid, mem_address, write_data_out,
      output mem_read_out, mem_write_out, reg_write_out,
      output rd_out, occupancy
   );

endinterface

// File: rtl/ex_dm_entry.sv
// Payload register with load enable and synchronous
// clear; clear wins over load.
module ex_dm_entry #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] pl_q, pl_d;

   always_comb begin
      pl_d = pl_q;
      if (clr)
         pl_d = '0;
      else if (ld)
         pl_d = d;
   end

   always_ff @(posedge clk) begin
      pl_q <= pl_d;
   end

   assign q = pl_q;

endmodule

// File: rtl/ex_dm_stage.sv
// EX->DM two-entry skid stage: main entry drives the
// outputs, skid absorbs one extra beat so in_ready is registered.
module ex_dm_stage
   import ex_dm_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_W   = RD_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   ex_dm_stage_if.slave bus
);

   localparam int PW = 2 * DATA_W + 3 + RD_W;

   state_e      state_q, state_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic [1:0]  occ_q, occ_d;

   logic [PW-1:0] in_pl, main_d, main_pl, skid_pl;
   logic          main_ld, skid_ld, clr;
   logic          in_fire, out_fire;

   logic [DATA_W-1:0] m_addr, m_wdata;
   logic              m_rd_en, m_wr_en, m_rw;
   logic [RD_W-1:0]   m_rd;

   assign in_pl = {bus.alu_result, bus.write_data_in,
                   bus.mem_read_in, bus.mem_write_in,
                   bus.reg_write_in, bus.rd_in};

   assign in_fire  = bus.in_valid & in_ready_q;
   assign out_fire = out_valid_q & bus.out_ready;
   assign clr      = reset | flush;

   always_comb begin
      state_d = state_q;
      main_ld = 1'b0;
      skid_ld = 1'b0;
      main_d  = in_pl;
      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               state_d = ONE;
               main_ld = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_ld = 1'b1;
            end else if (in_fire) begin
               state_d = FULL;
               skid_ld = 1'b1;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               state_d = ONE;
               main_ld = 1'b1;
               main_d  = skid_pl;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Squash drops both entries and any beat accepted this edge.
      if (flush) begin
         state_d = EMPTY;
         main_ld = 1'b0;
         skid_ld = 1'b0;
      end
      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
      occ_d       = occ_of(state_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         occ_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         occ_q       <= occ_d;
      end
   end

   ex_dm_entry #(.W(PW)) u_main (
      .clk (clk),
      .clr (clr),
      .ld  (main_ld),
      .d   (main_d),
      .q   (main_pl)
   );

   ex_dm_entry #(.W(PW)) u_skid (
      .clk (clk),
      .clr (clr),
      .ld  (skid_ld),
      .d   (in_pl),
      .q   (skid_pl)
   );

   assign {m_addr, m_wdata, m_rd_en, m_wr_en, m_rw, m_rd} = main_pl;

   assign bus.in_ready       = in_ready_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.occupancy      = occ_q;
   assign bus.mem_address    = m_addr;
   assign bus.write_data_out = m_wdata;
   assign bus.rd_out         = m_rd;
   assign bus.mem_read_out   = m_rd_en & out_valid_q;
   assign bus.mem_write_out  = m_wr_en & out_valid_q;
   assign bus.reg_write_out  = m_rw & out_valid_q;

endmodule

// File: tb/tb_ex_dm_stage.sv
// Bench for ex_dm_stage: directed vector table, streaming run,
// and randomized traffic against a queue-based reference.
module tb_ex_dm_stage;
   import ex_dm_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic flush;

   always #5 clk = ~clk;

   ex_dm_stage_if #(.DATA_W(32), .RD_W(5)) bus ();

   ex_dm_stage dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        mr;
      logic        mw;
      logic        rw;
      logic [4:0]  rd;
   } pl_t;

   typedef struct {
      logic        rst;
      logic        fl;
      logic        iv;
      logic [31:0] addr;
      logic        mr;
      logic        mw;
      logic        ordy;
      logic        e_ov;
      logic        e_ir;
      logic [1:0]  e_occ;
      logic        chk_addr;
      logic [31:0] e_addr;
      logic        e_mr;
      logic        e_mw;
   } vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   pl_t  mq[$];
   vec_t tbl[13];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(logic iv, pl_t p, logic ordy);
      bus.in_valid      = iv;
      bus.alu_result    = p.addr;
      bus.write_data_in = p.wdata;
      bus.mem_read_in   = p.mr;
      bus.mem_write_in  = p.mw;
      bus.reg_write_in  = p.rw;
      bus.rd_in         = p.rd;
      bus.out_ready     = ordy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic rst, logic fl, logic iv,
                               logic [31:0] a, logic mr, logic mw,
                               logic ordy, logic ov, logic ir,
                               logic [1:0] occ, logic ca,
                               logic [31:0] ea, logic emr, logic emw);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.addr = a;
      v.mr = mr; v.mw = mw; v.ordy = ordy;
      v.e_ov = ov; v.e_ir = ir; v.e_occ = occ;
      v.chk_addr = ca; v.e_addr = a == a ? ea : ea;
      v.e_mr = emr; v.e_mw = emw;
      return v;
   endfunction

   // Reference: the stage is a FIFO of depth two.
   task automatic model_edge(logic rst, logic fl, logic iv,
                             logic ordy, pl_t p);
      logic acc;
      acc = (mq.size() < 2);
      if (rst || fl) begin
         mq.delete();
      end else begin
         if (mq.size() > 0 && ordy) void'(mq.pop_front());
         if (iv && acc) mq.push_back(p);
      end
   endtask

   task automatic model_check(string tag);
      chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(mq.size() != 0));
      chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(mq.size() < 2));
      chk({tag, ".occupancy"}, 64'(bus.occupancy), 64'(mq.size()));
      if (mq.size() > 0) begin
         chk({tag, ".payload"},
             64'({bus.mem_address, bus.write_data_out} ^
                 {bus.rd_out, bus.mem_read_out, bus.mem_write_out,
                  bus.reg_write_out}),
             64'({mq[0].addr, mq[0].wdata} ^
                 {mq[0].rd, mq[0].mr, mq[0].mw, mq[0].rw}));
         chk({tag, ".addr"}, 64'(bus.mem_address), 64'(mq[0].addr));
      end else begin
         chk({tag, ".ctrl_idle"},
             64'({bus.mem_read_out, bus.mem_write_out,
                  bus.reg_write_out}), 64'(0));
      end
   endtask

   initial begin
      pl_t p;
      logic iv, ordy, rst, fl;

      reset = 1'b1;
      flush = 1'b0;
      p = '0;
      drive(1'b0, p, 1'b0);

      //        rst fl iv addr          mr mw rdy  ov ir occ ca addr      mr mw
      tbl[0]  = mk(1, 0, 0, 32'h0,      0, 0, 0,   0, 1, 0, 1, 32'h0,    0, 0);
      tbl[1]  = mk(0, 0, 1, 32'h1000,   1, 0, 1,   1, 1, 1, 1, 32'h1000, 1, 0);
      tbl[2]  = mk(0, 0, 0, 32'h0,      0, 0, 1,   0, 1, 0, 0, 32'h0,    0, 0);
      tbl[3]  = mk(0, 0, 1, 32'h10,     0, 0, 0,   1, 1, 1, 1, 32'h10,   0, 0);
      tbl[4]  = mk(0, 0, 1, 32'h20,     0, 0, 0,   1, 0, 2, 1, 32'h10,   0, 0);
      tbl[5]  = mk(0, 0, 1, 32'h30,     0, 0, 0,   1, 0, 2, 1, 32'h10,   0, 0);
      tbl[6]  = mk(0, 0, 0, 32'h0,      0, 0, 1,   1, 1, 1, 1, 32'h20,   0, 0);
      tbl[7]  = mk(0, 0, 0, 32'h0,      0, 0, 1,   0, 1, 0, 0, 32'h0,    0, 0);
      tbl[8]  = mk(0, 0, 1, 32'h40,     0, 1, 0,   1, 1, 1, 1, 32'h40,   0, 1);
      tbl[9]  = mk(0, 0, 1, 32'h50,     0, 1, 0,   1, 0, 2, 1, 32'h40,   0, 1);
      tbl[10] = mk(0, 1, 0, 32'h0,      0, 0, 0,   0, 1, 0, 0, 32'h0,    0, 0);
      tbl[11] = mk(0, 0, 1, 32'h60,     1, 0, 0,   1, 1, 1, 1, 32'h60,   1, 0);
      tbl[12] = mk(1, 1, 1, 32'h70,     1, 0, 0,   0, 1, 0, 1, 32'h0,    0, 0);

      for (int i = 0; i < 13; i++) begin
         reset = tbl[i].rst;
         flush = tbl[i].fl;
         p = '0;
         p.addr = tbl[i].addr;
         p.wdata = tbl[i].addr + 32'h5;
         p.mr = tbl[i].mr;
         p.mw = tbl[i].mw;
         p.rd = 5'd3;
         drive(tbl[i].iv, p, tbl[i].ordy);
         step();
         chk($sformatf("vec%0d.out_valid", i),
             64'(bus.out_valid), 64'(tbl[i].e_ov));
         chk($sformatf("vec%0d.in_ready", i),
             64'(bus.in_ready), 64'(tbl[i].e_ir));
         chk($sformatf("vec%0d.occupancy", i),
             64'(bus.occupancy), 64'(tbl[i].e_occ));
         chk($sformatf("vec%0d.mem_read_out", i),
             64'(bus.mem_read_out), 64'(tbl[i].e_mr));
         chk($sformatf("vec%0d.mem_write_out", i),
             64'(bus.mem_write_out), 64'(tbl[i].e_mw));
         if (tbl[i].chk_addr)
            chk($sformatf("vec%0d.mem_address", i),
                64'(bus.mem_address), 64'(tbl[i].e_addr));
         if (tbl[i].rst)
            chk($sformatf("vec%0d.reset_data", i),
                64'({bus.write_data_out, bus.rd_out, bus.reg_write_out}),
                64'(0));
      end

      // Streaming: one beat in and one out every edge.
      reset = 1'b0;
      flush = 1'b0;
      for (int i = 0; i < 8; i++) begin
         p = '0;
         p.addr = 32'(i);
         p.rw = 1'b1;
         p.rd = 5'(i + 1);
         drive(1'b1, p, 1'b1);
         step();
         chk($sformatf("stream%0d.addr", i), 64'(bus.mem_address), 64'(i));
         chk($sformatf("stream%0d.rd", i), 64'(bus.rd_out), 64'(i + 1));
         chk($sformatf("stream%0d.occ", i), 64'(bus.occupancy), 64'(1));
         chk($sformatf("stream%0d.in_ready", i), 64'(bus.in_ready), 64'(1));
      end
      drive(1'b0, p, 1'b1);
      step();
      chk("stream_drain.out_valid", 64'(bus.out_valid), 64'(0));

      // Randomized traffic from a clean reset.
      reset = 1'b1;
      drive(1'b0, p, 1'b0);
      step();
      mq.delete();
      reset = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         rst  = ($urandom_range(0, 149) == 0);
         fl   = ($urandom_range(0, 39) == 0);
         iv   = ($urandom_range(0, 99) < 60);
         ordy = ($urandom_range(0, 99) < 55);
         p.addr  = $urandom;
         p.wdata = $urandom;
         p.mr    = 1'($urandom);
         p.mw    = 1'($urandom);
         p.rw    = 1'($urandom);
         p.rd    = 5'($urandom);
         reset = rst;
         flush = fl;
         drive(iv, p, ordy);
         model_edge(rst, fl, iv, ordy, p);
         step();
         model_check($sformatf("rnd%0d", c));
      end

      reset = 1'b0;
      flush = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ex_dm_stage.md
EX_DM_STAGE -- requirements
Module: ex_dm_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of ALU result / memory address and store data.
REQ-002 Parameter RD_W, default 5, width of destination register index.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all held entries (branch/exception squash).
REQ-006 in_valid  input  1  EX stage presents an instruction.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 alu_result  input  DATA_W  effective address / ALU value.
REQ-009 write_data_in  input  DATA_W  store data.
REQ-010 mem_read_in, mem_write_in, reg_write_in  input  1 each  control bits.
REQ-011 rd_in  input  RD_W  destination register.
REQ-012 out_valid  output  1  DM stage entry valid.
REQ-013 out_ready  input  1  data memory accepts this cycle.
REQ-014 mem_address, write_data_out  output  DATA_W  registered copies of alu_result, write_data_in.
REQ-015 mem_read_out, mem_write_out, reg_write_out  output  1 each  registered control bits.
REQ-016 rd_out  output  RD_W  registered destination.
REQ-017 occupancy  output  2  entries held (0..2).

Function
REQ-018 Input transfer SHALL occur when in_valid && in_ready at a rising edge; output transfer when out_valid && out_ready.
REQ-019 Stage SHALL hold two entries: main (drives outputs) and skid; states EMPTY, ONE, FULL.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, driven from registered state only (no combinational path from out_ready).
REQ-021 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-022 EMPTY + input transfer -> ONE, data into main; latency one edge, visible on outputs the cycle after acceptance.
REQ-023 ONE + input, no output -> FULL, new data into skid, main unchanged.
REQ-024 ONE + output, no input -> EMPTY.
REQ-025 ONE + input + output same edge -> ONE, main replaced by new data.
REQ-026 FULL + output -> ONE, skid moved to main; FULL without output -> FULL, all data held stable.
REQ-027 mem_read_out, mem_write_out, reg_write_out SHALL be forced 0 whenever out_valid is 0; data outputs are don't-care then but SHALL NOT change while out_valid && !out_ready.
REQ-028 flush SHALL move state to EMPTY at that edge; any simultaneous input transfer is discarded; output transfer that edge still counts as completed toward memory.
REQ-029 reset SHALL take priority over flush and all transfers.
REQ-030 occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL.
REQ-031 Entries SHALL leave in acceptance order; no entry duplicated or dropped except by flush/reset.

Reset
REQ-032 On reset: state EMPTY, in_ready 1, out_valid 0, all control outputs 0, mem_address, write_data_out, rd_out 0, occupancy 0.
REQ-033 Reset mid-operation (ONE or FULL) SHALL discard both entries at that edge.

Structure
REQ-034 Shared package ex_dm_pkg SHALL hold the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and default DATA_W/RD_W constants.
REQ-035 One sub-module ex_dm_entry (parametrised payload register with load enable and synchronous clear) SHALL be instantiated twice, main and skid.

Verification
REQ-036 Reset then in_valid=1, alu_result=0x0000_1000, mem_read_in=1, out_ready=1 -> next cycle out_valid=1, mem_address=0x1000, mem_read_out=1, occupancy=1.
REQ-037 out_ready=0, push A(0x10) then B(0x20) -> occupancy 2, in_ready=0, mem_address=0x10 held; out_ready=1 -> 0x10 then 0x20 on consecutive cycles.
REQ-038 Streaming 8 entries 0x0..0x7 with out_ready=1 every cycle -> one output per cycle in order, occupancy stays 1, in_ready stays 1.
REQ-039 FULL with mem_write_out=1, assert flush -> next cycle out_valid=0, mem_write_out=0, occupancy 0, in_ready=1.
REQ-040 flush and reset asserted with in_valid=1 in state ONE -> next cycle all outputs at reset values, input not captured.
REQ-041 Random in_valid/out_ready over 1000 cycles vs scoreboard -> no loss, duplication or reordering; outputs stable while stalled.
